// File: rtl/tm_pkg.sv
// Shared definitions for the inference, predictor and collector stages.
//   DEF_CLASS_LEN / DEF_IMAGES : default class count and images per batch
//   CLASS_IDX_W / IMG_IDX_W    : index widths for the defaults
//   state_t                    : collector FSM states
//   idx_w()                    : index width for n items (minimum 1 bit)
package tm_pkg;

  localparam int DEF_CLASS_LEN = 4;
  localparam int DEF_IMAGES    = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLASS_IDX_W = idx_w(DEF_CLASS_LEN);
  localparam int IMG_IDX_W   = idx_w(DEF_IMAGES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder.
//   i_onehot    : class vector, nominally one-hot
//   o_idx       : index of the lowest set bit, 0 when no bit is set
//   o_ambiguous : vector has zero or more than one bit set
module onehot_encoder
  import tm_pkg::*;
#(
  parameter  int CLASS_LEN = DEF_CLASS_LEN,
  localparam int IDX_W     = idx_w(CLASS_LEN)
) (
  input  logic [CLASS_LEN-1:0] i_onehot,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_ambiguous
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    w_idx = '0;
    for (int i = CLASS_LEN - 1; i >= 0; i--) begin
      if (i_onehot[i]) w_idx = IDX_W'(i);
    end
  end

  assign o_idx       = w_idx;
  // v & (v-1) clears the lowest set bit; anything left means more than one hot.
  assign o_ambiguous = (i_onehot == '0) ||
                       ((i_onehot & (i_onehot - 1'b1)) != '0);

endmodule

// File: rtl/prediction_collector.sv
// Captures a batch of per-image predictions when result_valid pulses and streams
// one image per valid/ready beat, with correctness and ambiguity flags, plus
// saturating running image/correct counters.
//   clock, reset (async active-low)
//   result_valid, predicted_class, labels_in : batch capture
//   clear_stats                              : sync clear of counters and overrun
//   out_ready / out_valid, out_image_idx, out_class_idx, out_correct, out_ambiguous
//   busy, batch_done, overrun, image_count, correct_count
module prediction_collector
  import tm_pkg::*;
#(
  parameter  int CLASS_LEN = DEF_CLASS_LEN,
  parameter  int IMAGES    = DEF_IMAGES,
  parameter  int CNT_W     = 32,
  localparam int CI_W      = idx_w(CLASS_LEN),
  localparam int II_W      = idx_w(IMAGES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        result_valid,
  input  logic [IMAGES*CLASS_LEN-1:0] predicted_class,
  input  logic [IMAGES*CLASS_LEN-1:0] labels_in,
  input  logic                        clear_stats,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [II_W-1:0]             out_image_idx,
  output logic [CI_W-1:0]             out_class_idx,
  output logic                        out_correct,
  output logic                        out_ambiguous,
  output logic                        busy,
  output logic                        batch_done,
  output logic                        overrun,
  output logic [CNT_W-1:0]            image_count,
  output logic [CNT_W-1:0]            correct_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                      r_state;
  logic [IMAGES*CLASS_LEN-1:0] r_pred;
  logic [IMAGES*CLASS_LEN-1:0] r_label;
  logic [II_W-1:0]             r_idx;
  logic                        r_out_valid;
  logic [CI_W-1:0]             r_out_class_idx;
  logic                        r_out_correct;
  logic                        r_out_ambiguous;
  logic                        r_busy;
  logic                        r_batch_done;
  logic                        r_overrun;
  logic [CNT_W-1:0]            r_image_count;
  logic [CNT_W-1:0]            r_correct_count;

  logic                        w_accept;
  logic                        w_last;
  logic [II_W-1:0]             w_next_idx;
  logic [CLASS_LEN-1:0]        w_sel_pred;
  logic [CLASS_LEN-1:0]        w_sel_label;
  logic [CI_W-1:0]             w_cls;
  logic                        w_amb;
  logic                        w_correct;

  assign w_accept   = r_out_valid && out_ready;
  assign w_last     = (r_idx == II_W'(IMAGES - 1));
  assign w_next_idx = r_idx + 1'b1;

  // Beat data is registered one step ahead: in IDLE the encoder looks at image 0
  // of the incoming batch, in SEND it looks at the next image of the captured one.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_sel_pred  = predicted_class[CLASS_LEN-1:0];
      w_sel_label = labels_in[CLASS_LEN-1:0];
    end else begin
      w_sel_pred  = r_pred[w_next_idx*CLASS_LEN +: CLASS_LEN];
      w_sel_label = r_label[w_next_idx*CLASS_LEN +: CLASS_LEN];
    end
  end

  onehot_encoder #(
    .CLASS_LEN (CLASS_LEN)
  ) u_enc (
    .i_onehot    (w_sel_pred),
    .o_idx       (w_cls),
    .o_ambiguous (w_amb)
  );

  assign w_correct = (w_sel_pred == w_sel_label);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_pred          <= '0;
      r_label         <= '0;
      r_idx           <= '0;
      r_out_valid     <= 1'b0;
      r_out_class_idx <= '0;
      r_out_correct   <= 1'b0;
      r_out_ambiguous <= 1'b0;
      r_busy          <= 1'b0;
      r_batch_done    <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (result_valid) begin
            r_pred          <= predicted_class;
            r_label         <= labels_in;
            r_idx           <= '0;
            r_out_class_idx <= w_cls;
            r_out_correct   <= w_correct;
            r_out_ambiguous <= w_amb;
            r_out_valid     <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (w_last) begin
              r_out_valid  <= 1'b0;
              r_batch_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_idx           <= w_next_idx;
              r_out_class_idx <= w_cls;
              r_out_correct   <= w_correct;
              r_out_ambiguous <= w_amb;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // clear_stats takes priority over any increment or overrun set in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_image_count   <= '0;
      r_correct_count <= '0;
      r_overrun       <= 1'b0;
    end else if (clear_stats) begin
      r_image_count   <= '0;
      r_correct_count <= '0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_image_count <= sat_inc(r_image_count);
        if (r_out_correct) r_correct_count <= sat_inc(r_correct_count);
      end
      if (result_valid && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_image_idx = r_idx;
  assign out_class_idx = r_out_class_idx;
  assign out_correct   = r_out_correct;
  assign out_ambiguous = r_out_ambiguous;
  assign busy          = r_busy;
  assign batch_done    = r_batch_done;
  assign overrun       = r_overrun;
  assign image_count   = r_image_count;
  assign correct_count = r_correct_count;

endmodule

// File: tb/tb_prediction_collector.sv
module tb_prediction_collector;

  localparam int CL    = 4;
  localparam int IM    = 8;
  localparam int SAT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic result_valid = 1'b0;
  logic clear_stats = 1'b0;
  logic out_ready = 1'b0;
  logic [IM*CL-1:0] predicted_class = '0;
  logic [IM*CL-1:0] labels_in = '0;

  logic        out_valid, out_correct, out_ambiguous, busy, batch_done, overrun;
  logic [2:0]  out_image_idx;
  logic [1:0]  out_class_idx;
  logic [31:0] image_count, correct_count;

  logic        s_out_valid, s_out_correct, s_out_ambiguous, s_busy, s_batch_done, s_overrun;
  logic [2:0]  s_out_image_idx;
  logic [1:0]  s_out_class_idx;
  logic [SAT_W-1:0] s_image_count, s_correct_count;

  prediction_collector #(.CLASS_LEN(CL), .IMAGES(IM), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .result_valid(result_valid),
    .predicted_class(predicted_class), .labels_in(labels_in),
    .clear_stats(clear_stats), .out_ready(out_ready), .out_valid(out_valid),
    .out_image_idx(out_image_idx), .out_class_idx(out_class_idx),
    .out_correct(out_correct), .out_ambiguous(out_ambiguous), .busy(busy),
    .batch_done(batch_done), .overrun(overrun), .image_count(image_count),
    .correct_count(correct_count)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
  prediction_collector #(.CLASS_LEN(CL), .IMAGES(IM), .CNT_W(SAT_W)) dut_sat (
    .clock(clock), .reset(reset), .result_valid(result_valid),
    .predicted_class(predicted_class), .labels_in(labels_in),
    .clear_stats(clear_stats), .out_ready(out_ready), .out_valid(s_out_valid),
    .out_image_idx(s_out_image_idx), .out_class_idx(s_out_class_idx),
    .out_correct(s_out_correct), .out_ambiguous(s_out_ambiguous), .busy(s_busy),
    .batch_done(s_batch_done), .overrun(s_overrun), .image_count(s_image_count),
    .correct_count(s_correct_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int img;
    int cls;
    bit cor;
    bit amb;
  } beat_t;

  beat_t  exp_q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     phase = 0;      // 0 idle, 1 streaming, 2 done pulse
  longint t_img = 0;      // unbounded tallies since last clear
  longint t_cor = 0;
  bit     e_ovr = 1'b0;
  int     ready_mode = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint t, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (t > mx) ? mx : t;
  endfunction

  function automatic int lowest_bit(input logic [CL-1:0] v);
    for (int b = 0; b < CL; b++) if (v[b]) return b;
    return 0;
  endfunction

  // Reference model and monitor: checks the DUT against the model every cycle,
  // then advances the model with the inputs the next rising edge will see.
  initial begin : monitor
    bit    acc;
    beat_t b;
    logic [CL-1:0] p, l;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_counts", image_count | correct_count, 0);
        chk("rst_out_data", {out_image_idx, out_class_idx, out_correct, out_ambiguous}, 0);
        exp_q.delete();
        phase = 0; t_img = 0; t_cor = 0; e_ovr = 1'b0;
      end else begin
        chk("out_valid", out_valid, phase == 1);
        chk("busy", busy, phase != 0);
        chk("batch_done", batch_done, phase == 2);
        chk("overrun", overrun, e_ovr);
        chk("image_count", image_count, sat(t_img, 32));
        chk("correct_count", correct_count, sat(t_cor, 32));
        chk("sat_image_count", s_image_count, sat(t_img, SAT_W));
        chk("sat_correct_count", s_correct_count, sat(t_cor, SAT_W));
        chk("sat_out_valid", s_out_valid, out_valid);
        if (phase == 1 && exp_q.size() > 0) begin
          chk("beat_image_idx", out_image_idx, exp_q[0].img);
          chk("beat_class_idx", out_class_idx, exp_q[0].cls);
          chk("beat_correct", out_correct, exp_q[0].cor);
          chk("beat_ambiguous", out_ambiguous, exp_q[0].amb);
        end
        acc = (phase == 1) && out_ready;
        if (clear_stats) begin
          t_img = 0; t_cor = 0; e_ovr = 1'b0;
        end else begin
          if (acc && exp_q.size() > 0) begin
            t_img++;
            if (exp_q[0].cor) t_cor++;
          end
          if (result_valid && phase != 0) e_ovr = 1'b1;
        end
        case (phase)
          0: if (result_valid) begin
               for (int i = 0; i < IM; i++) begin
                 p = predicted_class[i*CL +: CL];
                 l = labels_in[i*CL +: CL];
                 b.img = i;
                 b.cls = lowest_bit(p);
                 b.cor = (p == l);
                 b.amb = ($countones(p) != 1);
                 exp_q.push_back(b);
               end
               phase = 1;
             end
          1: if (acc) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) phase = 2;
             end
          default: phase = 0;
        endcase
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin : ready_drv
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (cnt % 3 == 0); cnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input logic [IM*CL-1:0] p, input logic [IM*CL-1:0] l);
    @(posedge clock);
    #1;
    predicted_class = p;
    labels_in = l;
    result_valid = 1'b1;
    @(posedge clock);
    #1;
    result_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clock);
      if (batch_done) found = 1'b1;
    end
    chk("wait_batch_done", found, 1);
  endtask

  task automatic rand_batch(input int amb_pct, input int wrong_pct,
                            output logic [IM*CL-1:0] p, output logic [IM*CL-1:0] l);
    for (int i = 0; i < IM; i++) begin
      l[i*CL +: CL] = 4'b0001 << $urandom_range(0, CL - 1);
      if ($urandom_range(0, 99) < amb_pct)
        p[i*CL +: CL] = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 99) < wrong_pct)
        p[i*CL +: CL] = 4'b0001 << $urandom_range(0, CL - 1);
      else
        p[i*CL +: CL] = l[i*CL +: CL];
    end
  endtask

  initial begin : stim
    logic [IM*CL-1:0] p, l, p2, l2;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Basic: image i predicts class i%4, labels equal.
    ready_mode = 0;
    for (int i = 0; i < IM; i++) p[i*CL +: CL] = 4'b0001 << (i % CL);
    l = p;
    issue(p, l);
    wait_done();

    // Backpressure with random one-hot predictions.
    ready_mode = 1;
    rand_batch(0, 30, p, l);
    issue(p, l);
    wait_done();

    // Mismatch / ambiguous images.
    ready_mode = 2;
    for (int i = 0; i < IM; i++) l[i*CL +: CL] = 4'b0001 << (i % CL);
    p = l;
    p[2*CL +: CL] = 4'b0000;
    p[5*CL +: CL] = 4'b0110;
    issue(p, l);
    wait_done();

    // Overrun: second result_valid while streaming.
    ready_mode = 0;
    rand_batch(0, 0, p, l);
    issue(p, l);
    repeat (2) @(posedge clock);
    #1;
    rand_batch(50, 50, p2, l2);
    predicted_class = p2;
    labels_in = l2;
    result_valid = 1'b1;
    @(posedge clock);
    #1 result_valid = 1'b0;
    wait_done();

    // clear_stats coincident with an accepted correct beat.
    rand_batch(0, 0, p, l);
    issue(p, l);
    @(posedge clock);
    #1 clear_stats = 1'b1;
    @(posedge clock);
    #1 clear_stats = 1'b0;
    wait_done();

    // Randomized batches (narrow counters saturate along the way).
    for (int n = 0; n < 6; n++) begin
      ready_mode = 2;
      rand_batch(25, 40, p, l);
      issue(p, l);
      wait_done();
    end

    // Reset after three accepted beats, then a clean batch.
    ready_mode = 0;
    rand_batch(0, 20, p, l);
    issue(p, l);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    rand_batch(20, 30, p, l);
    issue(p, l);
    wait_done();

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
